// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM read/write controllers.
// - rd_state_t : read-sequencer FSM states
// - clog2_min1 : address width that stays at least 1 bit when there is one row
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECH   = 2'd1,
    DEVELOP = 2'd2,
    SENSE   = 2'd3
  } rd_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Phase-length counter used by the SRAM array sequencers.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : phase length minus one
//   dec        : count down by one; holds at zero
//   zero       : counter is zero, i.e. the current phase ends at the next edge
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_read_ctrl.sv
// Sequences one SRAM read: bitline precharge, wordline development, sense-amp
// enable, then capture of the sense-amp outputs.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake, req_addr sampled on accept
//   pre_en, wl_en, sa_en  : array controls (precharge, one-hot wordline, sense)
//   preout                : sense-amp outputs
//   rd_valid              : one-cycle pulse qualifying rd_data and rd_err
//   rd_data, rd_err       : captured word; rd_err flags addr >= ROWS
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so the controller
// holds exactly one read in flight; req_addr is ignored at all other edges.
module sram_read_ctrl
  import sram_pkg::*;
#(
  parameter  int COLS    = 16,
  parameter  int ROWS    = 16,
  parameter  int PRE_CYC = 2,
  parameter  int WL_CYC  = 3,
  localparam int AW      = clog2_min1(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [AW-1:0]   req_addr,
  output logic            req_ready,
  output logic            pre_en,
  output logic [ROWS-1:0] wl_en,
  output logic            sa_en,
  input  logic [COLS-1:0] preout,
  output logic            rd_valid,
  output logic [COLS-1:0] rd_data,
  output logic            rd_err
);

  localparam int CW = $clog2((PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC) + 1;
  localparam logic [CW-1:0] PRE_LEN = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] WL_LEN  = CW'(WL_CYC - 1);
  localparam logic [AW:0]   ROW_LIM = (AW + 1)'(ROWS);

  if (PRE_CYC < 1 || WL_CYC < 1 || ROWS < 1) begin : g_param_check
    $error("sram_read_ctrl: PRE_CYC, WL_CYC and ROWS must all be >= 1");
  end

  rd_state_t       state;
  logic [AW-1:0]   addr_q;
  logic            in_range;
  logic [ROWS-1:0] wl_set;
  logic            t_load;
  logic [CW-1:0]   t_load_val;
  logic            t_dec;
  logic            t_zero;

  // Out-of-range rows still run the full timing but never raise a wordline.
  assign in_range = ({1'b0, addr_q} < ROW_LIM);
  assign wl_set   = in_range ? (ROWS'(1) << addr_q) : '0;

  // Timer control: load the next phase length on entry to PRECH and DEVELOP,
  // otherwise count down while a timed phase is running.
  always_comb begin
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          t_load     = 1'b1;
          t_load_val = PRE_LEN;
        end
      end
      PRECH: begin
        if (t_zero) begin
          t_load     = 1'b1;
          t_load_val = WL_LEN;
        end else begin
          t_dec = 1'b1;
        end
      end
      DEVELOP: t_dec = !t_zero;
      default: ;
    endcase
  end

  sram_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      req_ready <= 1'b1;
      pre_en    <= 1'b0;
      wl_en     <= '0;
      sa_en     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= PRECH;
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            pre_en    <= 1'b1;
          end
        end
        PRECH: begin
          // Precharge drops on the same edge the wordline rises: no overlap.
          if (t_zero) begin
            state  <= DEVELOP;
            pre_en <= 1'b0;
            wl_en  <= wl_set;
          end
        end
        DEVELOP: begin
          if (t_zero) begin
            state <= SENSE;
            sa_en <= 1'b1;
          end
        end
        SENSE: begin
          state     <= IDLE;
          wl_en     <= '0;
          sa_en     <= 1'b0;
          req_ready <= 1'b1;
          rd_valid  <= 1'b1;
          rd_data   <= in_range ? preout : '0;
          rd_err    <= !in_range;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_read_ctrl.sv
module tb_sram_read_ctrl;

  localparam int PRE_A = 2;
  localparam int WL_A  = 3;
  localparam int L_A   = PRE_A + WL_A + 1;
  localparam int PRE_B = 1;
  localparam int WL_B  = 1;
  localparam int ROWS_B = 12;
  localparam int L_B   = PRE_B + WL_B + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default parameters
  logic        a_rst_n, a_req_valid, a_req_ready, a_pre_en, a_sa_en, a_rd_valid, a_rd_err;
  logic [3:0]  a_req_addr;
  logic [15:0] a_wl_en, a_preout, a_rd_data;

  // DUT B: PRE_CYC=1, WL_CYC=1, ROWS=12
  logic        b_rst_n, b_req_valid, b_req_ready, b_pre_en, b_sa_en, b_rd_valid, b_rd_err;
  logic [3:0]  b_req_addr;
  logic [11:0] b_wl_en;
  logic [15:0] b_preout, b_rd_data;

  sram_read_ctrl u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_addr(a_req_addr),
    .req_ready(a_req_ready), .pre_en(a_pre_en), .wl_en(a_wl_en), .sa_en(a_sa_en),
    .preout(a_preout), .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err)
  );

  sram_read_ctrl #(.COLS(16), .ROWS(ROWS_B), .PRE_CYC(PRE_B), .WL_CYC(WL_B)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .pre_en(b_pre_en), .wl_en(b_wl_en), .sa_en(b_sa_en),
    .preout(b_preout), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err)
  );

  // ---------------- reference state ----------------
  logic [3:0]  a_addrs[4];
  logic [15:0] a_datas[4];
  logic [15:0] a_last = '0;
  logic [15:0] b_last = '0;

  // ---------------- scoreboard / invariants ----------------
  logic [31:0] exp_q[$];      // accept edge numbers of in-flight reads on DUT A
  logic [15:0] prev_preout = '0;
  logic        a_rv_prev = 1'b0;
  logic        b_rv_prev = 1'b0;

  always @(negedge clk) begin
    if (!a_rst_n) begin
      exp_q.delete();
      a_rv_prev = 1'b0;
    end else begin
      if (a_rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_rd_valid cyc=%0d", cyc);
        end else begin
          int acc;
          acc = int'(exp_q.pop_front());
          if ((cyc - acc) != L_A || a_rd_data !== prev_preout || a_rd_err !== 1'b0) begin
            failures++;
            $display("FAIL sb_read latency=%0d/%0d data=%h/%h err=%b/0",
                     cyc - acc, L_A, a_rd_data, prev_preout, a_rd_err);
          end
        end
      end
      if (a_req_valid && a_req_ready) exp_q.push_back(32'(cyc + 1));
      checks++;
      if (!$onehot0(a_wl_en)) begin failures++; $display("FAIL a_onehot0 wl=%h", a_wl_en); end
      checks++;
      if (a_pre_en && (a_wl_en != '0)) begin failures++; $display("FAIL a_pre_wl_overlap wl=%h", a_wl_en); end
      checks++;
      if (a_sa_en && (a_wl_en == '0)) begin failures++; $display("FAIL a_sa_without_wl cyc=%0d", cyc); end
      checks++;
      if (a_rd_valid && a_rv_prev) begin failures++; $display("FAIL a_rd_valid_long cyc=%0d", cyc); end
      a_rv_prev = a_rd_valid;
    end
    prev_preout = a_preout;
    if (!b_rst_n) begin
      b_rv_prev = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(b_wl_en)) begin failures++; $display("FAIL b_onehot0 wl=%h", b_wl_en); end
      checks++;
      if (b_pre_en && (b_wl_en != '0)) begin failures++; $display("FAIL b_pre_wl_overlap wl=%h", b_wl_en); end
      checks++;
      if (b_rd_valid && b_rv_prev) begin failures++; $display("FAIL b_rd_valid_long cyc=%0d", cyc); end
      b_rv_prev = b_rd_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // n reads on DUT A from a_addrs/a_datas, req_valid held high between them.
  // poke: pulse req_valid with another address while the read is in flight.
  task automatic run_a(input int n, input bit poke);
    logic        exp_pre, exp_sa, exp_rv;
    logic [15:0] exp_wl;
    @(posedge clk); #1;
    a_req_valid = 1'b1;
    a_req_addr  = a_addrs[0];
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL run_a_idle_ready ready=%b required=1", a_req_ready);
    end
    for (int r = 0; r < n; r++) begin
      for (int j = 1; j <= L_A + 1; j++) begin
        @(posedge clk); #1;
        if (j == 1) begin
          if (r + 1 < n) a_req_addr = a_addrs[r + 1];
          else begin
            a_req_valid = 1'b0;
            a_req_addr  = 4'($urandom_range(0, 15));
          end
        end
        if (poke && j == 2) begin
          a_req_valid = 1'b1;
          a_req_addr  = ~a_addrs[r];
        end
        if (poke && j == 4) a_req_valid = 1'b0;
        // The word is only meaningful at the sensing edge; noise elsewhere.
        a_preout = (j == L_A) ? a_datas[r] : 16'($urandom);
        @(negedge clk);
        exp_pre = (j <= PRE_A);
        exp_wl  = (j > PRE_A && j <= L_A) ? (16'd1 << a_addrs[r]) : 16'd0;
        exp_sa  = (j == L_A);
        exp_rv  = (j == L_A + 1);
        checks++;
        if (a_pre_en !== exp_pre || a_wl_en !== exp_wl || a_sa_en !== exp_sa ||
            a_rd_valid !== exp_rv || a_req_ready !== exp_rv) begin
          failures++;
          $display("FAIL read_a_seq r=%0d j=%0d pre=%b/%b wl=%h/%h sa=%b/%b rv=%b/%b rdy=%b/%b",
                   r, j, a_pre_en, exp_pre, a_wl_en, exp_wl, a_sa_en, exp_sa,
                   a_rd_valid, exp_rv, a_req_ready, exp_rv);
        end
        if (exp_rv) a_last = a_datas[r];
        checks++;
        if (a_rd_data !== a_last || (exp_rv && a_rd_err !== 1'b0)) begin
          failures++;
          $display("FAIL read_a_data r=%0d j=%0d data=%h required=%h err=%b",
                   r, j, a_rd_data, a_last, a_rd_err);
        end
      end
    end
  endtask

  task automatic run_b(input logic [3:0] addr, input logic [15:0] dv);
    logic        in_rng, exp_pre, exp_sa, exp_rv;
    logic [11:0] exp_wl;
    in_rng = (int'(addr) < ROWS_B);
    @(posedge clk); #1;
    b_req_valid = 1'b1;
    b_req_addr  = addr;
    b_preout    = dv;
    @(negedge clk);
    checks++;
    if (b_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL run_b_idle_ready ready=%b required=1", b_req_ready);
    end
    for (int j = 1; j <= L_B + 1; j++) begin
      @(posedge clk); #1;
      if (j == 1) b_req_valid = 1'b0;
      @(negedge clk);
      exp_pre = (j <= PRE_B);
      exp_wl  = (in_rng && j > PRE_B && j <= L_B) ? (12'd1 << addr) : 12'd0;
      exp_sa  = (j == L_B);
      exp_rv  = (j == L_B + 1);
      checks++;
      if (b_pre_en !== exp_pre || b_wl_en !== exp_wl || b_sa_en !== exp_sa ||
          b_rd_valid !== exp_rv || b_req_ready !== exp_rv) begin
        failures++;
        $display("FAIL read_b_seq addr=%0d j=%0d pre=%b/%b wl=%h/%h sa=%b/%b rv=%b/%b rdy=%b/%b",
                 addr, j, b_pre_en, exp_pre, b_wl_en, exp_wl, b_sa_en, exp_sa,
                 b_rd_valid, exp_rv, b_req_ready, exp_rv);
      end
      if (exp_rv) begin
        b_last = in_rng ? dv : 16'd0;
        checks++;
        if (b_rd_data !== b_last || b_rd_err !== !in_rng) begin
          failures++;
          $display("FAIL read_b_data addr=%0d data=%h/%h err=%b/%b",
                   addr, b_rd_data, b_last, b_rd_err, !in_rng);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    a_req_addr = '0; b_req_addr = '0;
    a_preout = '0; b_preout = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || a_pre_en !== 1'b0 || a_wl_en !== 16'd0 || a_sa_en !== 1'b0 ||
        a_rd_valid !== 1'b0 || a_rd_data !== 16'd0 || a_rd_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_a rdy=%b pre=%b wl=%h sa=%b rv=%b data=%h err=%b required rdy=1 rest 0",
               a_req_ready, a_pre_en, a_wl_en, a_sa_en, a_rd_valid, a_rd_data, a_rd_err);
    end
    checks++;
    if (b_req_ready !== 1'b1 || b_pre_en !== 1'b0 || b_wl_en !== 12'd0 || b_sa_en !== 1'b0 ||
        b_rd_valid !== 1'b0 || b_rd_data !== 16'd0 || b_rd_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_b rdy=%b pre=%b wl=%h sa=%b rv=%b data=%h err=%b required rdy=1 rest 0",
               b_req_ready, b_pre_en, b_wl_en, b_sa_en, b_rd_valid, b_rd_data, b_rd_err);
    end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    a_addrs[0] = 4'd5;
    a_datas[0] = 16'hA5C3;
    run_a(1, 1'b0);
  endtask

  task automatic test_back_to_back;
    a_addrs[0] = 4'd0;  a_datas[0] = 16'h1234;
    a_addrs[1] = 4'd15; a_datas[1] = 16'hBEEF;
    run_a(2, 1'b0);
  endtask

  task automatic test_busy_poke;
    a_addrs[0] = 4'd9;
    a_datas[0] = 16'h5A5A;
    run_a(1, 1'b1);
  endtask

  task automatic test_small_params;
    run_b(4'd13, 16'hFFFF);
    run_b(4'd11, 16'h0F0F);
    run_b(4'd12, 16'h1357);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    a_req_valid = 1'b1;
    a_req_addr  = 4'd3;
    a_preout    = 16'hCAFE;
    @(posedge clk); #1;                 // accepting edge
    a_req_valid = 1'b0;
    repeat (PRE_A + 1) @(posedge clk);  // now in a development cycle
    #1;
    checks++;
    if (a_wl_en !== 16'h0008 || a_pre_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_develop wl=%h required=0008 pre=%b", a_wl_en, a_pre_en);
    end
    a_rst_n = 1'b0;
    #1;
    checks++;
    if (a_wl_en !== 16'd0 || a_sa_en !== 1'b0 || a_rd_valid !== 1'b0 ||
        a_pre_en !== 1'b0 || a_req_ready !== 1'b1 || a_rd_data !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_async wl=%h sa=%b rv=%b pre=%b rdy=%b data=%h required 0,0,0,0,1,0",
               a_wl_en, a_sa_en, a_rd_valid, a_pre_en, a_req_ready, a_rd_data);
    end
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    a_last  = 16'd0;
    for (int k = 0; k < L_A + 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_rd_valid !== 1'b0 || a_wl_en !== 16'd0) begin
        failures++;
        $display("FAIL reset_mid_discard k=%0d rv=%b wl=%h required 0", k, a_rd_valid, a_wl_en);
      end
    end
    a_addrs[0] = 4'd3;
    a_datas[0] = 16'h7E57;
    run_a(1, 1'b0);
  endtask

  task automatic test_random;
    int n;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        a_addrs[i] = 4'($urandom_range(0, 15));
        a_datas[i] = 16'($urandom);
      end
      run_a(n, ($urandom_range(0, 3) == 0) && (n == 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    for (int t = 0; t < 20; t++) begin
      run_b(4'($urandom_range(0, 15)), 16'($urandom));
    end
    repeat (L_A + 2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_outstanding size=%0d required=0", exp_q.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_busy_poke();
    test_small_params();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
